// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types for the control-signal pipeline.
// Condition codes, per-stage control bundle, flag bit positions.
package ctrl_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       pcsrc;
    logic       branch;
    logic [1:0] flagwrite;
    logic [3:0] cond;
  } ctrl_t;

  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

endpackage

// File: rtl/ctrl_pipe_cond_eval.sv
// cond_eval: ARM condition-code check against NZCV.
// Purely combinational; 1111 is treated as always.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[N];
  assign z = flags[Z];
  assign c = flags[C];
  assign v = flags[V];

  // Decode the condition field into a pass/fail predicate
  always_comb begin
    pass = 1'b1;
    unique case (cond_e'(cond))
      EQ:      pass = z;
      NE:      pass = ~z;
      CS:      pass = c;
      CC:      pass = ~c;
      MI:      pass = n;
      PL:      pass = ~n;
      VS:      pass = v;
      VC:      pass = ~v;
      HI:      pass = c & ~z;
      LS:      pass = ~c | z;
      GE:      pass = (n == v);
      LT:      pass = (n != v);
      GT:      pass = ~z & (n == v);
      LE:      pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded controls Decode..Writeback with
// stall/flush bubbles, NZCV tracking and condition squashing.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int NSTAGES   = 4,
  parameter int PAYLOAD_W = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             valid_d,
  input  logic                             regwrite_d,
  input  logic                             memwrite_d,
  input  logic                             memtoreg_d,
  input  logic                             branch_d,
  input  logic                             pcsrc_d,
  input  logic [1:0]                       flagwrite_d,
  input  logic [3:0]                       cond_d,
  input  logic [PAYLOAD_W-1:0]             payload_d,
  input  logic [3:0]                       alu_flags_e,
  input  logic [NSTAGES-2:0]               stall,
  input  logic [NSTAGES-2:0]               flush,
  output logic [NSTAGES-2:0]               valid_o,
  output logic [NSTAGES-2:0]               regwrite_o,
  output logic [NSTAGES-2:0]               memwrite_o,
  output logic [NSTAGES-2:0]               memtoreg_o,
  output logic [NSTAGES-2:0]               pcsrc_o,
  output logic [(NSTAGES-1)*PAYLOAD_W-1:0] payload_o,
  output logic                             condex_e,
  output logic                             branch_taken_e,
  output logic [3:0]                       flags_o
);

  localparam int S = NSTAGES - 1;

  logic [S-1:0]         hold;
  logic [S-1:0]         hold_prev;
  ctrl_t                dec;
  ctrl_t                st_q   [S];
  ctrl_t                st_d   [S];
  ctrl_t                src    [S];
  logic [PAYLOAD_W-1:0] pl_q   [S];
  logic [PAYLOAD_W-1:0] pl_d   [S];
  logic [PAYLOAD_W-1:0] pl_src [S];
  logic [3:0]           flags_q;
  logic [3:0]           flags_d;
  logic                 pass;
  logic                 flag_upd;
  logic                 unused_tail;

  assign dec = '{
    valid:     valid_d,
    regwrite:  regwrite_d,
    memwrite:  memwrite_d,
    memtoreg:  memtoreg_d,
    pcsrc:     pcsrc_d,
    branch:    branch_d,
    flagwrite: flagwrite_d,
    cond:      cond_d
  };

  for (genvar i = 0; i < S; i++) begin : g_hold
    assign hold[i] = |stall[S-1:i];
  end

  assign hold_prev = {hold[S-2:0], 1'b0};

  cond_eval u_cond (
    .cond  (st_q[0].cond),
    .flags (flags_q),
    .pass  (pass)
  );

  assign condex_e       = st_q[0].valid & pass;
  assign branch_taken_e = condex_e & st_q[0].branch;
  assign flags_o        = flags_q;

  // Per-register load source; Execute->Memory squashes failed writes
  always_comb begin
    src[0]    = dec;
    pl_src[0] = payload_d;
    for (int i = 1; i < S; i++) begin
      src[i]    = st_q[i-1];
      pl_src[i] = pl_q[i-1];
    end
    src[1].valid    = st_q[0].valid    & condex_e;
    src[1].regwrite = st_q[0].regwrite & condex_e;
    src[1].memwrite = st_q[0].memwrite & condex_e;
    src[1].pcsrc    = st_q[0].pcsrc    & condex_e;
  end

  // Flush beats hold; a held predecessor feeds a bubble forward
  always_comb begin
    for (int i = 0; i < S; i++) begin
      st_d[i] = src[i];
      pl_d[i] = pl_src[i];
      if (flush[i]) begin
        st_d[i] = '0;
        pl_d[i] = '0;
      end else if (hold[i]) begin
        st_d[i] = st_q[i];
        pl_d[i] = pl_q[i];
      end else if (hold_prev[i]) begin
        st_d[i] = '0;
        pl_d[i] = '0;
      end
    end
  end

  // Partial NZCV write only when the Execute instruction retires forward
  always_comb begin
    flag_upd = condex_e & ~hold[0];
    flags_d  = flags_q;
    if (flag_upd && st_q[0].flagwrite[1]) begin
      flags_d[N:Z] = alu_flags_e[N:Z];
    end
    if (flag_upd && st_q[0].flagwrite[0]) begin
      flags_d[C:V] = alu_flags_e[C:V];
    end
  end

  // Flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  for (genvar i = 0; i < S; i++) begin : g_stage
    ctrl_t                q;
    logic [PAYLOAD_W-1:0] p;

    // Pipeline register i+1
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q <= '0;
        p <= '0;
      end else begin
        q <= st_d[i];
        p <= pl_d[i];
      end
    end

    assign st_q[i]       = q;
    assign pl_q[i]       = p;
    assign valid_o[i]    = q.valid;
    assign regwrite_o[i] = q.regwrite;
    assign memwrite_o[i] = q.memwrite;
    assign memtoreg_o[i] = q.memtoreg;
    assign pcsrc_o[i]    = q.pcsrc;
    assign payload_o[i*PAYLOAD_W +: PAYLOAD_W] = p;
  end

  assign unused_tail = ^{st_q[S-1].branch,
                         st_q[S-1].flagwrite,
                         st_q[S-1].cond};

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: random + directed check of ctrl_pipe
// against an instruction-slot model of the pipeline.
module tb_ctrl_pipe;

  localparam int NS = 4;
  localparam int PW = 4;
  localparam int S  = NS - 1;

  logic            clk;
  logic            reset;
  logic            valid_d, regwrite_d, memwrite_d, memtoreg_d;
  logic            branch_d, pcsrc_d;
  logic [1:0]      flagwrite_d;
  logic [3:0]      cond_d;
  logic [PW-1:0]   payload_d;
  logic [3:0]      alu_flags_e;
  logic [S-1:0]    stall, flush;
  logic [S-1:0]    valid_o, regwrite_o, memwrite_o, memtoreg_o, pcsrc_o;
  logic [S*PW-1:0] payload_o;
  logic            condex_e, branch_taken_e;
  logic [3:0]      flags_o;

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ctrl_pipe #(.NSTAGES(NS), .PAYLOAD_W(PW)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_d        (valid_d),
    .regwrite_d     (regwrite_d),
    .memwrite_d     (memwrite_d),
    .memtoreg_d     (memtoreg_d),
    .branch_d       (branch_d),
    .pcsrc_d        (pcsrc_d),
    .flagwrite_d    (flagwrite_d),
    .cond_d         (cond_d),
    .payload_d      (payload_d),
    .alu_flags_e    (alu_flags_e),
    .stall          (stall),
    .flush          (flush),
    .valid_o        (valid_o),
    .regwrite_o     (regwrite_o),
    .memwrite_o     (memwrite_o),
    .memtoreg_o     (memtoreg_o),
    .pcsrc_o        (pcsrc_o),
    .payload_o      (payload_o),
    .condex_e       (condex_e),
    .branch_taken_e (branch_taken_e),
    .flags_o        (flags_o)
  );

  typedef struct {
    bit          v, rw, mw, mr, pc, br;
    bit [1:0]    fw;
    bit [3:0]    cd;
    bit [PW-1:0] pl;
  } ins_t;

  ins_t     m  [1:S];
  ins_t     nx [1:S];
  ins_t     empty;
  ins_t     inp;
  bit [3:0] mf;
  bit       cx;
  bit       here_held, prev_held;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit passes(bit [3:0] cd, bit [3:0] f);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cd)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  // Model: each slot holds one instruction record, moved by the stall/flush rules
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 1; k <= S; k++) m[k] = empty;
      mf = 4'b0000;
    end else begin
      cx = m[1].v && passes(m[1].cd, mf);
      if (cx && stall == 0) begin
        if (m[1].fw[1]) mf[3:2] = alu_flags_e[3:2];
        if (m[1].fw[0]) mf[1:0] = alu_flags_e[1:0];
      end
      inp.v  = valid_d;    inp.rw = regwrite_d; inp.mw = memwrite_d;
      inp.mr = memtoreg_d; inp.pc = pcsrc_d;    inp.br = branch_d;
      inp.fw = flagwrite_d; inp.cd = cond_d;    inp.pl = payload_d;
      for (int k = 1; k <= S; k++) begin
        here_held = (stall >> (k - 1)) != 0;
        prev_held = (k > 1) && ((stall >> (k - 2)) != 0);
        if (flush[k-1])     nx[k] = empty;
        else if (here_held) nx[k] = m[k];
        else if (prev_held) nx[k] = empty;
        else if (k == 1)    nx[k] = inp;
        else begin
          nx[k] = m[k-1];
          if (k == 2) begin
            nx[k].v  = m[1].v  && cx;
            nx[k].rw = m[1].rw && cx;
            nx[k].mw = m[1].mw && cx;
            nx[k].pc = m[1].pc && cx;
          end
        end
      end
      for (int k = 1; k <= S; k++) m[k] = nx[k];
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    logic [S-1:0]    ev, erw, emw, emr, epc;
    logic [S*PW-1:0] epl;
    logic            ecx;
    for (int k = 1; k <= S; k++) begin
      ev[k-1]  = m[k].v;  erw[k-1] = m[k].rw; emw[k-1] = m[k].mw;
      emr[k-1] = m[k].mr; epc[k-1] = m[k].pc;
      epl[(k-1)*PW +: PW] = m[k].pl;
    end
    ecx = m[1].v && passes(m[1].cd, mf);
    chk("valid_o",    32'(valid_o),    32'(ev));
    chk("regwrite_o", 32'(regwrite_o), 32'(erw));
    chk("memwrite_o", 32'(memwrite_o), 32'(emw));
    chk("memtoreg_o", 32'(memtoreg_o), 32'(emr));
    chk("pcsrc_o",    32'(pcsrc_o),    32'(epc));
    chk("payload_o",  32'(payload_o),  32'(epl));
    chk("condex_e",   32'(condex_e),   32'(ecx));
    chk("branch_taken_e", 32'(branch_taken_e), 32'(ecx && m[1].br));
    chk("flags_o",    32'(flags_o),    32'(mf));
  end

  task automatic idle();
    valid_d = 0; regwrite_d = 0; memwrite_d = 0; memtoreg_d = 0;
    branch_d = 0; pcsrc_d = 0; flagwrite_d = 0; cond_d = 0;
    payload_d = 0;
  endtask

  task automatic drive(bit rw, bit mw, bit br, bit [1:0] fw,
                       bit [3:0] cd, bit [PW-1:0] pl);
    valid_d = 1; regwrite_d = rw; memwrite_d = mw; memtoreg_d = 0;
    branch_d = br; pcsrc_d = 0; flagwrite_d = fw; cond_d = cd;
    payload_d = pl;
  endtask

  initial begin
    idle();
    stall = 0; flush = 0; alu_flags_e = 0;
    reset = 1;
    #2 reset = 0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_flags", 32'(flags_o), 0);
    chk("rst_payload", 32'(payload_o), 0);
    // flagwrite=01 with 1111 from 0000
    reset = 1;
    drive(1, 0, 0, 2'b01, 4'he, 4'h1);
    @(negedge clk); idle(); alu_flags_e = 4'hf;
    @(negedge clk);
    chk("fw01_flags", 32'(flags_o), 32'h3);
    // ADDS zero then BEQ
    drive(1, 0, 0, 2'b11, 4'he, 4'h5); alu_flags_e = 0;
    @(negedge clk);
    drive(0, 0, 1, 2'b00, 4'h0, 4'h6); alu_flags_e = 4'b0100;
    @(negedge clk);
    chk("adds_flags", 32'(flags_o), 32'h4);
    chk("beq_taken", 32'(branch_taken_e), 1);
    chk("beq_condex", 32'(condex_e), 1);
    // STRNE while Z=1
    drive(0, 1, 0, 2'b00, 4'h1, 4'h7); alu_flags_e = 0;
    @(negedge clk);
    chk("strne_condex", 32'(condex_e), 0);
    idle();
    @(negedge clk);
    chk("strne_memwrite", 32'(memwrite_o[1]), 0);
    chk("strne_valid", 32'(valid_o[1]), 0);
    // stall=010 for two cycles
    drive(1, 0, 0, 2'b00, 4'he, 4'h1);
    @(negedge clk); drive(1, 0, 0, 2'b00, 4'he, 4'h2);
    @(negedge clk); drive(1, 0, 0, 2'b00, 4'he, 4'h3);
    @(negedge clk);
    chk("fill_valid", 32'(valid_o), 32'h7);
    stall = 3'b010; drive(1, 0, 0, 2'b00, 4'he, 4'h4);
    @(negedge clk);
    chk("stall1_payload", 32'(payload_o), 32'h023);
    chk("stall1_valid", 32'(valid_o), 32'h3);
    @(negedge clk);
    chk("stall2_payload", 32'(payload_o), 32'h023);
    stall = 0;
    @(negedge clk);
    chk("resume_payload", 32'(payload_o), 32'h234);
    // stall+flush on register 1
    drive(1, 0, 0, 2'b11, 4'he, 4'h9);
    @(negedge clk);
    stall = 3'b001; flush = 3'b001; alu_flags_e = 4'hf; idle();
    @(negedge clk);
    chk("sf_valid0", 32'(valid_o[0]), 0);
    chk("sf_valid1", 32'(valid_o[1]), 0);
    chk("sf_flags", 32'(flags_o), 32'h4);
    stall = 0; flush = 0; alu_flags_e = 0;
    // reset mid-stream
    drive(1, 0, 0, 2'b00, 4'he, 4'h1);
    @(negedge clk); drive(1, 0, 0, 2'b00, 4'he, 4'h2);
    @(negedge clk); drive(1, 0, 0, 2'b00, 4'he, 4'h3);
    @(negedge clk);
    chk("pre_rst_valid", 32'(valid_o), 32'h7);
    idle();
    #2 reset = 0;
    #1;
    chk("mid_rst_valid", 32'(valid_o), 0);
    chk("mid_rst_regwrite", 32'(regwrite_o), 0);
    chk("mid_rst_payload", 32'(payload_o), 0);
    chk("mid_rst_flags", 32'(flags_o), 0);
    @(negedge clk);
    reset = 1; drive(1, 0, 0, 2'b00, 4'he, 4'ha);
    @(negedge clk); idle();
    @(negedge clk);
    chk("lat_wb_early", 32'(valid_o[2]), 0);
    @(negedge clk);
    chk("lat_wb_valid", 32'(valid_o[2]), 1);
    chk("lat_wb_payload", 32'(payload_o[11:8]), 32'ha);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      valid_d     = ($urandom_range(0, 3) != 0);
      regwrite_d  = 1'($urandom);
      memwrite_d  = 1'($urandom);
      memtoreg_d  = 1'($urandom);
      branch_d    = 1'($urandom);
      pcsrc_d     = 1'($urandom);
      flagwrite_d = 2'($urandom);
      cond_d      = ($urandom_range(0, 3) == 0) ? 4'he : 4'($urandom);
      payload_d   = PW'($urandom);
      alu_flags_e = 4'($urandom);
      stall = ($urandom_range(0, 7) == 0) ? S'($urandom) : '0;
      flush = ($urandom_range(0, 11) == 0) ? S'($urandom) : '0;
      @(negedge clk);
    end
    idle(); stall = 0; flush = 0;
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
